// File: rtl/nonce_sweep_ctrl.sv
// Nonce sweep controller: walks a [nonce_lo, nonce_hi] range in fixed-size
// batches, launches the hash engine per batch, scans the returned H0 words
// against a target and reports the first hit, a timeout, or range completion.
module nonce_sweep_ctrl #(
  parameter int unsigned NONCES_PER_BATCH = 16,
  parameter int unsigned TIMEOUT_CYCLES   = 4095
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] nonce_lo,
  input  logic [31:0] nonce_hi,
  input  logic [31:0] target,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [31:0] found_nonce,
  output logic        timeout_err,
  output logic [15:0] batches,
  output logic        eng_start,
  output logic [31:0] eng_base,
  input  logic        eng_done,
  input  logic        res_valid,
  input  logic [31:0] res_h0
);

  localparam int IW = (NONCES_PER_BATCH > 1) ? $clog2(NONCES_PER_BATCH) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [IW-1:0] LAST_BEAT  = IW'(NONCES_PER_BATCH - 1);
  localparam logic [32:0]   BATCH_STEP = 33'(NONCES_PER_BATCH);
  localparam logic [TW-1:0] TMO_LIMIT  = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_COLLECT,
    S_NEXT,
    S_REPORT
  } state_t;

  state_t        state;
  state_t        state_n;

  logic [31:0]   cur;          // base nonce of the current batch
  logic [31:0]   hi_q;
  logic [31:0]   tgt_q;
  logic          abort_pend;
  logic [TW-1:0] tcnt;
  logic [IW-1:0] beat_idx;

  logic [32:0]   beat_nonce;   // 33 bits so a batch straddling 2^32 never aliases
  logic [32:0]   next_base;
  logic          beat_hit;
  logic          sweep_stop;
  logic          tmo_expired;

  assign beat_nonce  = {1'b0, cur} + 33'(beat_idx);
  assign next_base   = {1'b0, cur} + BATCH_STEP;
  assign tmo_expired = (tcnt == TMO_LIMIT);

  // A beat counts only inside COLLECT, below target, within range, and only
  // until the first hit of the sweep has been latched.
  assign beat_hit = (state == S_COLLECT) && res_valid && (res_h0 < tgt_q) &&
                    (beat_nonce <= {1'b0, hi_q}) && !found;

  // An abort arriving in NEXT itself is honoured at this same boundary.
  assign sweep_stop = found || abort_pend || abort || (next_base > {1'b0, hi_q});

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      // NOTE: every clocked register uses <= so all flops update from the
      // pre-edge values; a blocking = here would create order-dependent races.
      state <= state_n;
    end
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned, which would otherwise infer a latch.
    state_n   = state;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    eng_start = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_n = (nonce_lo > nonce_hi) ? S_REPORT : S_LAUNCH;
      end
      S_LAUNCH: begin
        eng_start = 1'b1;
        state_n   = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done)         state_n = S_COLLECT;
        else if (tmo_expired) state_n = S_REPORT;
      end
      S_COLLECT: begin
        if (res_valid && (beat_idx == LAST_BEAT)) state_n = S_NEXT;
      end
      S_NEXT: begin
        state_n = sweep_stop ? S_REPORT : S_LAUNCH;
      end
      S_REPORT: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign eng_base = cur;

  // Sweep datapath: capture on start, count timeout/beats, latch the first hit,
  // and advance the batch base.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur         <= '0;
      hi_q        <= '0;
      tgt_q       <= '0;
      abort_pend  <= 1'b0;
      tcnt        <= '0;
      beat_idx    <= '0;
      found       <= 1'b0;
      found_nonce <= '0;
      timeout_err <= 1'b0;
      batches     <= '0;
    end else begin
      if ((state != S_IDLE) && abort) abort_pend <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            cur         <= nonce_lo;
            hi_q        <= nonce_hi;
            tgt_q       <= target;
            abort_pend  <= 1'b0;
            found       <= 1'b0;
            found_nonce <= '0;
            timeout_err <= 1'b0;
            batches     <= '0;
          end
        end
        S_LAUNCH: begin
          tcnt     <= '0;
          beat_idx <= '0;
        end
        S_WAIT: begin
          if (!eng_done) begin
            tcnt <= tcnt + 1'b1;
            if (tmo_expired) timeout_err <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (res_valid) beat_idx <= beat_idx + 1'b1;
          if (beat_hit) begin
            found       <= 1'b1;
            found_nonce <= beat_nonce[31:0];
          end
        end
        S_NEXT: begin
          if (batches != 16'hFFFF) batches <= batches + 16'd1;
          if (!sweep_stop) cur <= next_base[31:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Directed bench for nonce_sweep_ctrl: a small behavioural hash engine answers
// each launch, and every observable result is compared against hand-derived
// values.
module tb_nonce_sweep_ctrl;

  localparam int N   = 16;
  localparam int TMO = 10;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] nonce_lo;
  logic [31:0] nonce_hi;
  logic [31:0] target;
  logic        abort;
  logic        busy;
  logic        done;
  logic        found;
  logic [31:0] found_nonce;
  logic        timeout_err;
  logic [15:0] batches;
  logic        eng_start;
  logic [31:0] eng_base;
  logic        eng_done;
  logic        res_valid;
  logic [31:0] res_h0;

  int errors = 0;
  int checks = 0;
  int n_starts = 0;

  // Engine behaviour knobs: two hit nonces, one nonce whose H0 equals a given
  // value, and the H0 returned for every other nonce.
  logic [31:0] hit_a, hit_b, eq_n, eq_val, default_h0;

  nonce_sweep_ctrl #(
    .NONCES_PER_BATCH(N),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .nonce_lo   (nonce_lo),
    .nonce_hi   (nonce_hi),
    .target     (target),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .found_nonce(found_nonce),
    .timeout_err(timeout_err),
    .batches    (batches),
    .eng_start  (eng_start),
    .eng_base   (eng_base),
    .eng_done   (eng_done),
    .res_valid  (res_valid),
    .res_h0     (res_h0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count launch pulses mid-cycle, away from the active edge.
  always @(negedge clk) if (eng_start === 1'b1) n_starts++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] h0_of(input logic [31:0] n);
    if (n == hit_a || n == hit_b) return 32'h0;
    if (n == eq_n)                return eq_val;
    return default_h0;
  endfunction

  task automatic do_start(input logic [31:0] lo, input logic [31:0] hi, input logic [31:0] tgt);
    nonce_lo = lo;
    nonce_hi = hi;
    target   = tgt;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Answer one launch: wait for eng_start, stay `delay` cycles in WAIT
  // (optionally driving stray result beats), pulse eng_done, then return
  // n_beats result beats, pulsing abort alongside beat abort_at.
  task automatic serve_batch(input int delay, input bit noise, input int abort_at,
                             input int n_beats, output int waited, output logic [31:0] base);
    waited = 0;
    while (eng_start !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    check("eng_start_seen", eng_start, 1);
    base = eng_base;
    tick();
    repeat (delay) begin
      if (noise) begin
        res_valid = 1'b1;
        res_h0    = 32'h0;
      end
      tick();
    end
    res_valid = 1'b0;
    eng_done  = 1'b1;
    tick();
    eng_done  = 1'b0;
    for (int i = 0; i < n_beats; i++) begin
      res_valid = 1'b1;
      res_h0    = h0_of(base + 32'(i));
      abort     = (i == abort_at);
      tick();
    end
    res_valid = 1'b0;
    res_h0    = 32'h0;
    abort     = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (done !== 1'b1 && cyc < 200);
  endtask

  initial begin
    int          w, cyc, s0;
    logic [31:0] b;

    reset_n = 1'b1; start = 1'b0; nonce_lo = '0; nonce_hi = '0; target = '0;
    abort = 1'b0; eng_done = 1'b0; res_valid = 1'b0; res_h0 = '0;
    hit_a = 32'hDEAD_0000; hit_b = 32'hDEAD_0001; eq_n = 32'hDEAD_0002;
    eq_val = '0; default_h0 = 32'd1;

    // Reset state.
    #2 reset_n = 1'b0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_base", eng_base, 0);
    check("rst_batches", batches, 0);
    check("rst_found", found, 0);
    reset_n = 1'b1;
    tick();
    check("post_rst_no_launch", eng_start, 0);
    check("post_rst_idle", busy, 0);

    // Three full batches over 0..47, nothing below target 0.
    s0 = n_starts;
    do_start(32'd0, 32'd47, 32'd0);
    check("sw1_busy", busy, 1);
    serve_batch(2, 0, -1, N, w, b);
    check("sw1_base0", b, 32'd0);
    // A start while busy must not disturb the sweep.
    nonce_lo = 32'h500; nonce_hi = 32'h0; start = 1'b1;
    tick();
    start = 1'b0;
    serve_batch(2, 0, -1, N, w, b);
    check("sw1_base1", b, 32'd16);
    serve_batch(2, 0, -1, N, w, b);
    check("sw1_turnaround", w, 1);
    check("sw1_base2", b, 32'd32);
    wait_done(cyc);
    check("sw1_done", done, 1);
    check("sw1_found", found, 0);
    check("sw1_batches", batches, 3);
    check("sw1_launches", n_starts - s0, 3);
    tick();
    check("sw1_busy_after", busy, 0);
    check("sw1_done_pulse", done, 0);

    // First hit at 0x125 wins over 0x12A; H0 == target is not a hit; stray
    // beats during WAIT are ignored; 0xFFFFFFFF is large when unsigned.
    hit_a = 32'h125; hit_b = 32'h12A; eq_n = 32'h118; eq_val = 32'h10;
    default_h0 = 32'hFFFF_FFFF;
    s0 = n_starts;
    do_start(32'h100, 32'h1FF, 32'h10);
    serve_batch(3, 1, -1, N, w, b);
    check("sw2_base0", b, 32'h100);
    serve_batch(1, 0, -1, N, w, b);
    serve_batch(1, 0, -1, N, w, b);
    check("sw2_base2", b, 32'h120);
    wait_done(cyc);
    check("sw2_done", done, 1);
    check("sw2_found", found, 1);
    check("sw2_found_nonce", found_nonce, 32'h125);
    check("sw2_batches", batches, 3);
    check("sw2_launches", n_starts - s0, 3);
    tick(); tick();
    check("sw2_found_held", found, 1);

    // Empty range: straight to REPORT with no launch; results cleared.
    s0 = n_starts;
    do_start(32'd5, 32'd4, 32'h10);
    check("empty_done", done, 1);
    check("empty_found_cleared", found, 0);
    check("empty_batches", batches, 0);
    tick();
    check("empty_done_pulse", done, 0);
    check("empty_busy", busy, 0);
    check("empty_launches", n_starts - s0, 0);

    // Engine never answers: timeout 12 cycles after the launch sample
    // (one LAUNCH-to-WAIT step plus counter values 0..10 in WAIT).
    hit_a = 32'hDEAD_0000; hit_b = 32'hDEAD_0001; eq_n = 32'hDEAD_0002;
    default_h0 = 32'd1;
    do_start(32'd0, 32'd15, 32'd0);
    check("tmo_launch", eng_start, 1);
    wait_done(cyc);
    check("tmo_cycles", cyc, TMO + 2);
    check("tmo_err", timeout_err, 1);
    check("tmo_batches", batches, 0);
    tick();

    // eng_done on the expiry cycle wins over the timeout.
    do_start(32'd0, 32'd15, 32'd0);
    serve_batch(TMO, 0, -1, N, w, b);
    wait_done(cyc);
    check("tie_done", done, 1);
    check("tie_no_tmo", timeout_err, 0);
    check("tie_batches", batches, 1);
    tick();

    // Top of the nonce space: one batch, no wrap to 0.
    s0 = n_starts;
    do_start(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd0);
    serve_batch(1, 0, -1, N, w, b);
    check("top_base", b, 32'hFFFF_FFF0);
    wait_done(cyc);
    check("top_done", done, 1);
    check("top_batches", batches, 1);
    repeat (4) tick();
    check("top_launches", n_starts - s0, 1);
    check("top_busy", busy, 0);

    // Abort mid-batch: the batch completes, then the sweep stops.
    s0 = n_starts;
    do_start(32'd0, 32'h0000_FFFF, 32'd0);
    serve_batch(1, 0, 5, N, w, b);
    wait_done(cyc);
    check("abort_done", done, 1);
    check("abort_latency", cyc, 1);
    check("abort_batches", batches, 1);
    check("abort_launches", n_starts - s0, 1);
    tick();

    // Reset while collecting, then a clean sweep.
    do_start(32'h40, 32'h7F, 32'd0);
    serve_batch(1, 0, -1, 5, w, b);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_eng_start", eng_start, 0);
    check("mid_rst_eng_base", eng_base, 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("mid_rst_no_launch", eng_start, 0);
    hit_a = 32'h203;
    default_h0 = 32'hFFFF_FFFF;
    s0 = n_starts;
    do_start(32'h200, 32'h20F, 32'h10);
    serve_batch(2, 0, -1, N, w, b);
    check("clean_base", b, 32'h200);
    wait_done(cyc);
    check("clean_done", done, 1);
    check("clean_found", found, 1);
    check("clean_found_nonce", found_nonce, 32'h203);
    check("clean_batches", batches, 1);
    check("clean_launches", n_starts - s0, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
